ticket_sched: RTL

TICKET_SCHED -- requirements
Module: ticket_sched

---
 rtl/ticket_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ticket_sched.sv
// Ticket dispenser and caller: a 16-entry ticket ring served by three counters.
// Counters are granted round-robin and uncollected tickets are skipped after TIMEOUT cycles.
module ticket_sched #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
  input  logic [2:0] call_req,
  input  logic       arrive,
  input  logic       absent,
  output logic [3:0] issued_num,
  output logic [3:0] serve_num,
  output logic [1:0] serve_ctr,
  output logic       call_valid,
  output logic       served,
  output logic       skipped,
  output logic [3:0] queue_len,
  output logic       full,
  output logic       empty
);

  typedef enum logic {StIdle, StCall} state_e;

  state_e     state_q, state_d;
  logic [3:0] head_q, head_d, tail_q, tail_d, qlen_q, qlen_d, timer_q, timer_d;
  logic [3:0] issued_q, issued_d, serve_num_q, serve_num_d;
  logic [2:0] pending_q, pending_d;
  logic [1:0] last_q, last_d, serve_ctr_q, serve_ctr_d, grant_idx, cand;
  logic       served_q, served_d, skipped_q, skipped_d, grant_vld;
  logic       in_call, take_ok, do_serve, do_skip, deq, grant_go;

  assign in_call  = (state_q == StCall);
  assign take_ok  = take & (qlen_q != 4'd15);
  assign do_serve = in_call & arrive;
  assign do_skip  = in_call & ~arrive & (absent | (timer_q == 4'(TIMEOUT - 1)));
  assign deq      = do_serve | do_skip;
  assign grant_go = ~in_call & grant_vld & (qlen_q != 4'd0);
  assign qlen_d   = qlen_q + {3'b000, take_ok} - {3'b000, deq};

  // Round-robin search starts at the counter after the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant_go) state_d = StCall;
      StCall: begin
        if (do_serve)                         state_d = StIdle;
        else if (do_skip && qlen_d == 4'd0)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d      = head_q + {3'b000, deq};
    tail_d      = tail_q + {3'b000, take_ok};
    issued_d    = take_ok ? tail_q : issued_q;
    pending_d   = pending_q | call_req;
    last_d      = last_q;
    timer_d     = in_call ? timer_q + 4'd1 : timer_q;
    serve_num_d = serve_num_q;
    serve_ctr_d = serve_ctr_q;
    served_d    = do_serve;
    skipped_d   = do_skip;
    if (grant_go) begin
      pending_d[grant_idx] = 1'b0;
      last_d               = grant_idx;
      serve_num_d          = head_q;
      serve_ctr_d          = grant_idx;
      timer_d              = 4'd0;
    end
    // A skip keeps the same counter and moves on to the next waiting ticket.
    if (do_skip) begin
      serve_num_d = head_q + 4'd1;
      timer_d     = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= 4'd0;
      tail_q      <= 4'd0;
      qlen_q      <= 4'd0;
      timer_q     <= 4'd0;
      issued_q    <= 4'd0;
      serve_num_q <= 4'd0;
      serve_ctr_q <= 2'd0;
      pending_q   <= 3'b000;
      last_q      <= 2'd2;
      served_q    <= 1'b0;
      skipped_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      qlen_q      <= qlen_d;
      timer_q     <= timer_d;
      issued_q    <= issued_d;
      serve_num_q <= serve_num_d;
      serve_ctr_q <= serve_ctr_d;
      pending_q   <= pending_d;
      last_q      <= last_d;
      served_q    <= served_d;
      skipped_q   <= skipped_d;
    end
  end

  assign issued_num = issued_q;
  assign serve_num  = serve_num_q;
  assign serve_ctr  = serve_ctr_q;
  assign call_valid = in_call;
  assign served     = served_q;
  assign skipped    = skipped_q;
  assign queue_len  = qlen_q;
  assign full       = (qlen_q == 4'd15);
  assign empty      = (qlen_q == 4'd0);

endmodule
